// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port image memory.
// master = arbiter side, slave = requesters plus memory model side.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          we0;
  logic          we1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic [DW-1:0] rdata;
  logic          rvalid0;
  logic          rvalid1;
  logic [AW-1:0] addr;
  logic [DW-1:0] dataW;
  logic          en;
  logic          we;
  logic [DW-1:0] dataR;

  modport master (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, dataR,
    output gnt0, gnt1, rdata, rvalid0, rvalid1, addr, dataW, en, we
  );

  modport slave (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, dataR,
    input  gnt0, gnt1, rdata, rvalid0, rvalid1, addr, dataW, en, we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the image memory between Sobel (0) and host (1).
// Optional access/wait statistics counters are compiled in when ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int AW        = 16,
  parameter int DW        = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
`ifdef ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_acc0,
  output logic [31:0]        stat_acc1,
  output logic [31:0]        stat_wait
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          last_reg, last_next;
  logic [1:0]    gnt_reg;
  logic [1:0]    rvalid_reg, rvalid_next;

  logic [1:0]    req;
  logic [1:0]    we_in;
  logic [AW-1:0] addr_in  [2];
  logic [DW-1:0] wdata_in [2];

  logic          owner;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          en_mux;
  logic          we_mux;

  assign req         = {bus.req1, bus.req0};
  assign we_in       = {bus.we1, bus.we0};
  assign addr_in[0]  = bus.addr0;
  assign addr_in[1]  = bus.addr1;
  assign wdata_in[0] = bus.wdata0;
  assign wdata_in[1] = bus.wdata1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      gnt_reg    <= '0;
      rvalid_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      gnt_reg    <= {state_next == OWN1, state_next == OWN0};
      rvalid_reg <= rvalid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req[0] && req[1]) state_next = last_reg ? OWN0 : OWN1;
        else if (req[0])      state_next = OWN0;
        else if (req[1])      state_next = OWN1;
      end
      OWN0: begin
        if (!req[0])                           state_next = req[1] ? OWN1 : IDLE;
        else if (req[1] && cnt_reg == CNT_MAX) state_next = OWN1;
      end
      OWN1: begin
        if (!req[1])                           state_next = req[0] ? OWN0 : IDLE;
        else if (req[0] && cnt_reg == CNT_MAX) state_next = OWN0;
      end
      default: state_next = IDLE;
    endcase

    // A fresh owner restarts its burst; a continuing owner counts up and saturates.
    cnt_next  = cnt_reg;
    last_next = last_reg;
    if (state_next == IDLE) begin
      cnt_next = '0;
    end else if (state_next != state_reg) begin
      cnt_next  = '0;
      last_next = (state_next == OWN1);
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  always_comb begin
    owner       = (state_reg == OWN1);
    addr_mux    = '0;
    wdata_mux   = '0;
    en_mux      = 1'b0;
    we_mux      = 1'b0;
    rvalid_next = '0;
    if (state_reg != IDLE) begin
      addr_mux  = addr_in[owner];
      wdata_mux = wdata_in[owner];
      en_mux    = req[owner];
      we_mux    = req[owner] & we_in[owner];
      rvalid_next[owner] = req[owner] & ~we_in[owner];
    end
  end

  assign bus.addr    = addr_mux;
  assign bus.dataW   = wdata_mux;
  assign bus.en      = en_mux;
  assign bus.we      = we_mux;
  assign bus.rdata   = bus.dataR;
  assign bus.gnt0    = gnt_reg[0];
  assign bus.gnt1    = gnt_reg[1];
  assign bus.rvalid0 = rvalid_reg[0];
  assign bus.rvalid1 = rvalid_reg[1];

`ifdef ARB_STATS_EN
  logic [31:0] acc_reg [2];
  logic [31:0] wait_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_acc
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             acc_reg[gi] <= '0;
      else if (stat_clr)                      acc_reg[gi] <= '0;
      else if (en_mux && owner == 1'(gi))     acc_reg[gi] <= acc_reg[gi] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    wait_reg <= '0;
    else if (stat_clr)             wait_reg <= '0;
    else if (|(req & ~gnt_reg))    wait_reg <= wait_reg + 32'd1;
  end

  assign stat_acc0 = acc_reg[0];
  assign stat_acc1 = acc_reg[1];
  assign stat_wait = wait_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_BURST=4) with a registered-read memory model.
// Statistics checks are included when ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   fail_count;

  logic [31:0] mem [0:65535];

  mem_port_arbiter_if #(.AW(16), .DW(32)) bus ();

`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_acc0;
  logic [31:0] stat_acc1;
  logic [31:0] stat_wait;
`endif

  mem_port_arbiter #(.MAX_BURST(4), .AW(16), .DW(32)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_acc0(stat_acc0),
    .stat_acc1(stat_acc1),
    .stat_wait(stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.we) mem[bus.addr] <= bus.dataW;
      else        bus.dataR     <= mem[bus.addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0;   bus.req1 = 1'b0;
    bus.we0  = 1'b0;   bus.we1  = 1'b0;
    bus.addr0 = '0;    bus.addr1 = '0;
    bus.wdata0 = '0;   bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rst_n      = 1'b0;
    bus.dataR  = '0;
`ifdef ARB_STATS_EN
    stat_clr   = 1'b0;
`endif
    clear_inputs();
    mem[16'h0010] = 32'h1234_5678;
    mem[16'h0020] = 32'hCAFE_0020;
    mem[16'h0030] = 32'hBEEF_0030;
    #2;
    check_eq("rst_gnt0", bus.gnt0, 1'b0);
    check_eq("rst_gnt1", bus.gnt1, 1'b0);
    check_eq("rst_en", bus.en, 1'b0);
    check_eq("rst_addr", bus.addr, 16'h0);
    check_eq("rst_rvalid0", bus.rvalid0, 1'b0);

    // Single read by requester 0
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    #1;
    check_eq("t1_idle_gnt0", bus.gnt0, 1'b0);
    check_eq("t1_idle_en", bus.en, 1'b0);
    step();
    check_eq("t1_gnt0", bus.gnt0, 1'b1);
    check_eq("t1_en", bus.en, 1'b1);
    check_eq("t1_addr", bus.addr, 16'h0010);
    step();
    check_eq("t1_rvalid0", bus.rvalid0, 1'b1);
    check_eq("t1_rdata", bus.rdata, 32'h1234_5678);
    check_eq("t1_rvalid1", bus.rvalid1, 1'b0);
    bus.req0 = 1'b0;
    #1;
    check_eq("t1_drop_en", bus.en, 1'b0);
    step();
    check_eq("t1_end_gnt0", bus.gnt0, 1'b0);
    check_eq("t1_end_rvalid0", bus.rvalid0, 1'b0);

    // Tie after reset goes to 0, then handover to 1 without a gap
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 16'h0020;
    bus.req1 = 1'b1; bus.addr1 = 16'h0030;
    step();
    check_eq("t2_gnt0", bus.gnt0, 1'b1);
    check_eq("t2_gnt1", bus.gnt1, 1'b0);
    check_eq("t2_addr", bus.addr, 16'h0020);
    step();
    check_eq("t2_rvalid0", bus.rvalid0, 1'b1);
    check_eq("t2_rdata", bus.rdata, 32'hCAFE_0020);
    bus.req0 = 1'b0;
    #1;
    check_eq("t2_drop_en", bus.en, 1'b0);
    step();
    check_eq("t2_ho_gnt1", bus.gnt1, 1'b1);
    check_eq("t2_ho_gnt0", bus.gnt0, 1'b0);
    check_eq("t2_ho_en", bus.en, 1'b1);
    check_eq("t2_ho_addr", bus.addr, 16'h0030);
    check_eq("t2_ho_rvalid0", bus.rvalid0, 1'b0);
    step();
    check_eq("t2_rvalid1", bus.rvalid1, 1'b1);
    check_eq("t2_rdata1", bus.rdata, 32'hBEEF_0030);

    // Both held: ownership alternates every 4 cycles
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    bus.req1 = 1'b1; bus.addr1 = 16'h0020;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j <= 12) begin
        check_eq($sformatf("t3_gnt0_c%0d", j), bus.gnt0, ((j - 1) / 4) % 2 == 0);
        check_eq($sformatf("t3_gnt1_c%0d", j), bus.gnt1, ((j - 1) / 4) % 2 == 1);
      end
    end
`ifdef ARB_STATS_EN
    check_eq("st_acc_sum", stat_acc0 + stat_acc1, 32'd19);
    check_eq("st_wait", stat_wait, 32'd20);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check_eq("st_clr_acc0", stat_acc0, 32'd0);
    check_eq("st_clr_acc1", stat_acc1, 32'd0);
    check_eq("st_clr_wait", stat_wait, 32'd0);
`endif

    // Requester 1 alone: five writes then a read-back
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h6300; bus.wdata1 = 32'hA5A5_A5A0;
    step();
    check_eq("t4_gnt1", bus.gnt1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.addr1  = 16'h6300 + 16'(i);
      bus.wdata1 = 32'hA5A5_A5A0 + 32'(i);
      #1;
      check_eq($sformatf("t4_we_%0d", i), bus.we, 1'b1);
      check_eq($sformatf("t4_addr_%0d", i), bus.addr, 16'h6300 + 16'(i));
      check_eq($sformatf("t4_dataW_%0d", i), bus.dataW, 32'hA5A5_A5A0 + 32'(i));
      check_eq($sformatf("t4_rvalid1_%0d", i), bus.rvalid1, 1'b0);
      check_eq($sformatf("t4_rvalid0_%0d", i), bus.rvalid0, 1'b0);
      step();
    end
    bus.we1 = 1'b0; bus.addr1 = 16'h6302;
    #1;
    check_eq("t4_rd_we", bus.we, 1'b0);
    step();
    check_eq("t4_rvalid1", bus.rvalid1, 1'b1);
    check_eq("t4_rdata", bus.rdata, 32'hA5A5_A5A2);
    check_eq("t4_rd_rvalid0", bus.rvalid0, 1'b0);

    // Reset mid-burst in OWN1 clears outputs at once
    rst_n = 1'b0;
    #2;
    check_eq("t5_gnt1", bus.gnt1, 1'b0);
    check_eq("t5_en", bus.en, 1'b0);
    check_eq("t5_we", bus.we, 1'b0);
    check_eq("t5_rvalid1", bus.rvalid1, 1'b0);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    step();
    check_eq("t5_hold_gnt0", bus.gnt0, 1'b0);
    check_eq("t5_hold_rvalid1", bus.rvalid1, 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("t5_rel_gnt0", bus.gnt0, 1'b1);
    check_eq("t5_rel_gnt1", bus.gnt1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single-port image memory used by the edge-detection design. It shares the memory bus (addr/dataR/dataW/en/we) between the Sobel accelerator (requester 0) and the host loader/readback path (requester 1). It uses round-robin ownership with a bounded burst length and forwards read data with a per-requester valid strobe. The block sits between both requesters and the memory model, replacing their direct connections.

## Interface
- MAX_BURST, 16: max consecutive owned cycles while the other requester waits; legal range 2..255.
- AW, 16: address width (halfword_t).
- DW, 32: data width (word_t).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is synchronous to clk.
- req0, req1  in  1 each  bus request, held high for as long as ownership is wanted.
- addr0, addr1  in  AW  requester address.
- we0, we1  in  1  requester write enable.
- wdata0, wdata1  in  DW  requester write data.
- gnt0, gnt1  out  1 each  registered ownership flag; at most one is high.
- rdata  out  DW  equals dataR, broadcast to both requesters.
- rvalid0, rvalid1  out  1  rdata holds the result of that requester's read issued in the previous cycle.
- addr  out  AW  to memory.
- dataW  out  DW  to memory.
- en  out  1  to memory.
- we  out  1  to memory.
- dataR  in  DW  from memory; valid one cycle after a read access.

## Operation
- States: IDLE, OWN0, OWN1. State, gnt, burst counter `cnt` (8 bit), last-served pointer `last` and rvalid are registers.
- Memory mux (combinational):
  - In OWNx: addr=addrx, dataW=wdatax, we=wex&reqx, en=reqx.
  - In IDLE: addr=0, dataW=0, en=0, we=0.
- IDLE:
  - Only req0 high → OWN0.
  - Only req1 high → OWN1.
  - Both high → grant the requester ≠ `last`.
  - Neither high → stay in IDLE.
- OWNx, reqx low → if req_other is high, go to OWNother, else IDLE. A dropped request issues no access in that cycle.
- OWNx, reqx high:
  - cnt increments each cycle.
  - If cnt == MAX_BURST−1 and req_other is high → go to OWNother (forced yield).
  - If req_other is low → cnt saturates at MAX_BURST−1 and ownership is kept.
- On entering any OWN state: cnt=0 and `last`=new owner.
- rvalidx is set next cycle iff this cycle was OWNx with reqx=1 and wex=0. Writes never raise rvalid.
- Requesters must hold addr/we/wdata stable only in cycles where gntx=1. Inputs are ignored while not granted.

## Timing
- Reset values: state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, cnt=0, `last`=1 (so requester 0 wins the first tie). Memory outputs are 0 via the IDLE mux.
- Grant latency: req rising in cycle t from IDLE → gnt in t+1. The first access is in t+1.
- Read latency: access in cycle t → rdata/rvalid in t+1.
- Handover: the old owner's final access is in cycle t and the new owner's gnt is in t+1. There is no dead cycle between owners.
- Worst-case wait for a requester while the other is streaming: MAX_BURST+1 cycles.
- Reset asserted mid-burst: outputs drop to reset values asynchronously. A read issued in the cycle before reset gets no rvalid.
- Simultaneous drop of reqx and rise of req_other: treated as a handover, so gnt_other is set next cycle.

## Configuration
- ARB_STATS_EN defined → adds:
  - stat_clr (in, 1): synchronous clear of all counters.
  - stat_acc0, stat_acc1 (out, 32): count cycles with en=1 per owner.
  - stat_wait (out, 32): counts cycles where any reqx=1 and gntx=0.
  - All counters wrap at 2^32 and reset to 0.
- ARB_STATS_EN undefined → these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset then req0=1, we0=0, addr0=0x0010 held → gnt0 rises one cycle later. en=1, addr=0x0010. rvalid0=1 with rdata=mem[0x0010] the following cycle.
- req0 and req1 rise in the same cycle after reset → gnt0 first. When req0 drops, gnt1 follows with no idle cycle between owners.
- MAX_BURST=4, req0 and req1 both held high → ownership alternates every 4 cycles: gnt0 ×4, gnt1 ×4, ...
- req1 alone with 5 writes (addr 0x6300..0x6304, data 0xA5A5A5A0+i), then a read of 0x6302 → rdata=0xA5A5A5A2 and rvalid1=1. rvalid0 stays 0 throughout.
- reset pulled low mid-burst while in OWN1 → gnt1, en, we, rvalid drop to 0 immediately. After release with only req0 high, the next owner is requester 0.
- With ARB_STATS_EN defined, run scenario 3 for 20 cycles → stat_acc0+stat_acc1=19 (the grant-latency cycle has no access). stat_clr then reads 0 on all counters.
